// File: rtl/ma_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ma_window_scheduler
// Brief    : Round-robin sequencer feeding one sample per cycle into the shared
//            moving-average datapath, with per-channel clear and window fill.
// Revision : 1.0 - initial release
// ============================================================================
module ma_window_scheduler #(
  parameter int NCH    = 3,
  parameter int WINDOW = 4,
  parameter int DW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH*DW-1:0] req_data,
  output logic [NCH-1:0]    req_ready,
  output logic              dp_valid,
  output logic [1:0]        dp_chan,
  output logic [DW-1:0]     dp_data,
  output logic              dp_clear,
  output logic [NCH-1:0]    win_full,
  output logic              busy
);

  localparam logic [3:0] C_WINDOW = 4'(WINDOW);
  localparam logic [1:0] C_LAST   = 2'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_clr_idx;
  logic [1:0]    r_rr_ptr;
  logic [3:0]    r_fill_cnt [NCH];

  logic          w_found;
  logic [1:0]    w_gidx;
  logic [DW-1:0] w_gdata;
  logic          w_run_ok;

  assign w_run_ok = (r_state == S_RUN) && en && !flush;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin : p_arb
    int c;
    c       = 0;
    w_found = 1'b0;
    w_gidx  = '0;
    w_gdata = '0;
    for (int k = 1; k <= NCH; k++) begin
      c = (int'(r_rr_ptr) + k) % NCH;
      if (!w_found && req_valid[c]) begin
        w_found = 1'b1;
        w_gidx  = 2'(c);
        w_gdata = req_data[c*DW +: DW];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_run_ok && w_found) begin
      req_ready[w_gidx] = 1'b1;
    end
  end

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_win
      assign win_full[g] = (r_fill_cnt[g] == C_WINDOW);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_clr_idx <= '0;
      r_rr_ptr  <= C_LAST;
      dp_valid  <= 1'b0;
      dp_clear  <= 1'b0;
      dp_chan   <= '0;
      dp_data   <= '0;
      busy      <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        r_fill_cnt[c] <= '0;
      end
    end else begin
      dp_valid <= 1'b0;
      dp_clear <= 1'b0;
      dp_chan  <= '0;
      dp_data  <= '0;
      busy     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
          end
        end
        S_CLEAR: begin
          dp_clear <= 1'b1;
          dp_chan  <= r_clr_idx;
          busy     <= 1'b1;
          for (int c = 0; c < NCH; c++) begin
            if (2'(c) == r_clr_idx) begin
              r_fill_cnt[c] <= '0;
            end
          end
          if (r_clr_idx == C_LAST) begin
            r_state <= S_RUN;
          end else begin
            r_clr_idx <= r_clr_idx + 2'd1;
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
          end else if (!en) begin
            r_state <= S_IDLE;
          end else if (w_found) begin
            dp_valid <= 1'b1;
            dp_chan  <= w_gidx;
            dp_data  <= w_gdata;
            r_rr_ptr <= w_gidx;
            for (int c = 0; c < NCH; c++) begin
              if (2'(c) == w_gidx && r_fill_cnt[c] != C_WINDOW) begin
                r_fill_cnt[c] <= r_fill_cnt[c] + 4'd1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ma_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ma_window_scheduler
// Brief    : Vector table, directed corner sequences and randomized traffic
//            checked against a behavioural model of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ma_window_scheduler;

  localparam int NCH    = 3;
  localparam int WINDOW = 4;
  localparam int DW     = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              flush;
  logic [NCH-1:0]    req_valid;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    req_ready;
  logic              dp_valid;
  logic [1:0]        dp_chan;
  logic [DW-1:0]     dp_data;
  logic              dp_clear;
  logic [NCH-1:0]    win_full;
  logic              busy;

  int checks = 0;
  int errors = 0;

  ma_window_scheduler #(.NCH(NCH), .WINDOW(WINDOW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .dp_valid(dp_valid), .dp_chan(dp_chan), .dp_data(dp_data),
    .dp_clear(dp_clear), .win_full(win_full), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 idle, 1 clearing, 2 running.
  int         m_phase;
  int         m_cidx;
  int         m_last;
  int         m_fill [NCH];
  logic       e_valid, e_clear, e_busy;
  logic [1:0] e_chan;
  logic [1:0] e_data;

  function automatic logic [NCH-1:0] model_full();
    logic [NCH-1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++) r[c] = (m_fill[c] >= WINDOW);
    return r;
  endfunction

  function automatic int model_grant();
    if (m_phase != 2 || !en || flush) return -1;
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (m_last + k) % NCH;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cidx = 0; m_last = NCH - 1;
    for (int c = 0; c < NCH; c++) m_fill[c] = 0;
    e_valid = 0; e_clear = 0; e_busy = 0; e_chan = 0; e_data = 0;
  endtask

  task automatic model_edge(input int g);
    e_valid = 0; e_clear = 0; e_busy = 0; e_chan = 0; e_data = 0;
    if (m_phase == 1) begin
      e_clear = 1; e_busy = 1; e_chan = 2'(m_cidx);
      m_fill[m_cidx] = 0;
      m_cidx++;
      if (m_cidx == NCH) m_phase = 2;
    end else if (m_phase == 0) begin
      if (en) begin m_phase = 1; m_cidx = 0; end
    end else begin
      if (flush) begin m_phase = 1; m_cidx = 0; end
      else if (!en) m_phase = 0;
      else if (g >= 0) begin
        e_valid = 1; e_chan = 2'(g);
        e_data = req_data[g*DW +: DW];
        m_fill[g] = (m_fill[g] + 1 > WINDOW) ? WINDOW : m_fill[g] + 1;
        m_last = g;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic check_outputs();
    chk("dp_valid", 32'(dp_valid), 32'(e_valid));
    chk("dp_clear", 32'(dp_clear), 32'(e_clear));
    chk("dp_chan",  32'(dp_chan),  32'(e_chan));
    chk("dp_data",  32'(dp_data),  32'(e_data));
    chk("busy",     32'(busy),     32'(e_busy));
    chk("win_full", 32'(win_full), 32'(model_full()));
  endtask

  // Called at a falling edge; leaves at the next falling edge.
  task automatic cycle(input logic e, input logic f, input logic [NCH-1:0] v,
                       input logic [NCH*DW-1:0] d);
    int g;
    logic [NCH-1:0] er;
    en = e; flush = f; req_valid = v; req_data = d;
    #1;
    g  = model_grant();
    er = (g >= 0) ? NCH'(1 << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    @(posedge clk);
    model_edge(g);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; flush = 0; req_valid = '0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    check_outputs();
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
  endtask

  typedef struct {
    logic       e;
    logic       f;
    logic [2:0] v;
    logic [5:0] d;
    logic [2:0] rdy;
    logic       ov;
    logic       oc;
    logic [1:0] och;
    logic [1:0] od;
    logic       ob;
    logic [2:0] owf;
  } vec_t;

  vec_t tbl [16];

  initial begin
    rst_n = 0; en = 0; flush = 0; req_valid = '0; req_data = '0;
    model_reset();

    // Start-up: one idle->clear edge, three clears, then 12 all-valid grants.
    for (int i = 0; i < 4; i++) begin
      tbl[i] = '{e:1, f:0, v:3'b000, d:6'b111001, rdy:3'b000, ov:0,
                 oc:(i > 0), och:2'((i > 0) ? i - 1 : 0), od:0, ob:(i > 0), owf:3'b000};
    end
    for (int i = 0; i < 12; i++) begin
      logic [2:0] wf;
      wf = '0;
      for (int c = 0; c < 3; c++) begin
        int n;
        n = i / 3 + ((c <= i % 3) ? 1 : 0);
        wf[c] = (n >= 4);
      end
      tbl[4+i] = '{e:1, f:0, v:3'b111, d:6'b111001, rdy:3'(1 << (i % 3)), ov:1,
                   oc:0, och:2'(i % 3), od:2'(i % 3 + 1), ob:0, owf:wf};
    end

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      int g;
      en = tbl[i].e; flush = tbl[i].f; req_valid = tbl[i].v; req_data = tbl[i].d;
      #1;
      g = model_grant();
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      model_edge(g);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 32'(dp_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_clear", i), 32'(dp_clear), 32'(tbl[i].oc));
      chk($sformatf("tbl%0d_chan", i),  32'(dp_chan),  32'(tbl[i].och));
      chk($sformatf("tbl%0d_data", i),  32'(dp_data),  32'(tbl[i].od));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),     32'(tbl[i].ob));
      chk($sformatf("tbl%0d_wfull", i), 32'(win_full), 32'(tbl[i].owf));
    end

    // Flush beats a valid ch0 request, then a full clear empties the windows.
    cycle(1, 1, 3'b001, 6'b000001);
    chk("flush_no_valid", 32'(dp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 3'b000, 6'b0);
      chk("flush_clear", 32'(dp_clear), 32'd1);
      chk("flush_chan",  32'(dp_chan),  32'(i));
    end
    chk("flush_wfull", 32'(win_full), 32'd0);

    // Channel 1 alone: back-to-back grants, window saturates after 4.
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 3'b010, 6'b001000);
      chk("ch1_data",  32'(dp_data),     32'd2);
      chk("ch1_chan",  32'(dp_chan),     32'd1);
      chk("ch1_wfull", 32'(win_full[1]), 32'(i >= 3));
    end

    // Drop en after two ch2 transfers, then re-enable.
    cycle(1, 0, 3'b100, 6'b110000);
    cycle(1, 0, 3'b100, 6'b110000);
    cycle(0, 0, 3'b100, 6'b110000);
    chk("endrop_wfull", 32'(win_full), 32'b010);
    cycle(0, 0, 3'b100, 6'b110000);
    chk("idle_novalid", 32'(dp_valid), 32'd0);
    cycle(1, 0, 3'b000, 6'b0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 3'b000, 6'b0);
    chk("reen_wfull", 32'(win_full), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 3'b100, 6'b110000);
    chk("ch2_restart", 32'(win_full[2]), 32'd0);
    cycle(1, 0, 3'b100, 6'b110000);
    chk("ch2_full", 32'(win_full[2]), 32'd1);

    // Reset in the middle of the clear sequence.
    do_reset();
    cycle(1, 0, 3'b000, 6'b0);
    cycle(1, 0, 3'b000, 6'b0);
    chk("midclr_ch0", 32'(dp_clear), 32'd1);
    do_reset();
    chk("midclr_rst_clear", 32'(dp_clear), 32'd0);
    cycle(1, 0, 3'b000, 6'b0);
    cycle(1, 0, 3'b000, 6'b0);
    chk("midclr_restart", 32'(dp_chan), 32'd0);
    chk("midclr_restart_clr", 32'(dp_clear), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 19) != 0), ($urandom_range(0, 39) == 0),
              NCH'($urandom), (NCH*DW)'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ma_window_scheduler.md
# ma_window_scheduler

Sequencer and round-robin arbiter in front of the shared 2-bit moving-average datapath. The datapath holds one window accumulator per channel but accepts only one sample per cycle. This block does three things:
- Time-multiplexes the per-channel requesters (x, y, t) onto the datapath.
- Issues the per-channel clear sequence at start-up and on flush.
- Tracks window fill per channel, so downstream logic knows when each average is valid to publish.

## Interface
Parameters:
- NCH, 3, number of requesting channels (1..4)
- WINDOW, 4, moving-average window length in samples (2..15)
- DW, 2, sample width in bits

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  run enable; low parks the scheduler in IDLE
- flush  in  1  restart all windows (level; sampled each cycle)
- req_valid  in  NCH  per-channel sample valid
- req_data  in  NCH*DW  packed samples, channel c at [c*DW +: DW]
- req_ready  out  NCH  one-hot grant, combinational; transfer = req_valid[c] & req_ready[c]
- dp_valid  out  1  registered sample strobe to datapath
- dp_chan  out  2  registered channel index of dp_data / dp_clear
- dp_data  out  DW  registered sample
- dp_clear  out  1  registered clear strobe for accumulator dp_chan
- win_full  out  NCH  channel c has received at least WINDOW samples since its last clear
- busy  out  1  high while in CLEAR

## Operation
- States: IDLE, CLEAR, RUN.
- IDLE:
  - req_ready = 0; nothing is issued.
  - Stay while en = 0. When en = 1, go to CLEAR with clear index 0.
- CLEAR:
  - One channel per cycle, index 0..NCH-1. Each cycle registers dp_clear = 1 with dp_chan = index, zeroes fill_cnt[index] and win_full[index], and holds req_ready = 0.
  - After index NCH-1, go to RUN.
  - Exactly NCH cycles long. en and flush are ignored inside CLEAR.
- RUN:
  - If flush = 1: go to CLEAR with index 0; req_ready = 0 in that cycle (flush beats any transfer).
  - Else if en = 0: go to IDLE; fill counters and the rr pointer are preserved.
  - Else: round-robin arbitration. Grant the first c with req_valid[c] = 1, searching from rr_ptr+1 modulo NCH. On a grant, set rr_ptr to c.
  - When no requester is valid, req_ready = 0 and rr_ptr does not change.
- Per-channel fill counter:
  - Width 4 bits, saturates at WINDOW.
  - Increments on each transfer of that channel.
  - win_full[c] = (fill_cnt[c] == WINDOW).
- dp_valid and dp_clear are never high in the same cycle. dp_data = 0 whenever dp_valid = 0.
- Fairness: a continuously valid requester is granted within NCH RUN cycles.

## Timing
- Reset (rst_n = 0 at a rising edge) forces, on that edge:
  - state = IDLE; rr_ptr = NCH-1, so channel 0 has first priority.
  - All fill_cnt = 0.
  - dp_valid, dp_clear, dp_chan, dp_data, win_full, busy = 0.
  - req_ready = 0 combinationally while in IDLE.
- Reset mid-CLEAR or mid-RUN: abandons the sequence. No partial clear is remembered; a full CLEAR runs again on the next en.
- Transfer latency: a transfer at edge N gives dp_valid, dp_chan, dp_data at N+1. win_full updates on the same edge N+1.
- en rising: first dp_clear appears 1 cycle after the edge at which en is sampled high in IDLE. The first req_ready is possible NCH+1 cycles after that edge.
- Throughput: one transfer per cycle in RUN, sustained.
- busy = 1 exactly for the NCH cycles the state is CLEAR, aligned with the dp_clear pulses.
- Saturation: transfers past WINDOW still issue dp_valid; fill_cnt holds at WINDOW.

## Test plan
- Reset then en = 1 with NCH = 3: dp_clear pulses for chan 0, 1, 2 on three consecutive cycles, busy = 1 for those 3 cycles, then RUN. No req_ready before cycle 4.
- All three req_valid held high in RUN: grants go 0, 1, 2, 0, 1, 2. dp_chan follows one cycle later with the matching dp_data. win_full[c] rises after its 4th transfer, i.e. win_full = 3'b111 after 12 transfers.
- Only channel 1 valid, data 2'b10, for 6 cycles: 6 back-to-back grants to ch1 with dp_data = 2'b10. win_full[1] rises on the 4th dp_valid and stays high. fill_cnt[1] stays at 4.
- flush asserted in the same cycle as a valid ch0 request: no grant, no dp_valid next cycle; a 3-cycle CLEAR follows and win_full returns to 0.
- en dropped in RUN after 2 ch2 transfers, then raised again: state goes to IDLE with win_full unchanged; re-enable runs a full CLEAR and fill_cnt[2] restarts at 0.
- rst_n pulsed low mid-CLEAR (after chan 0 cleared): all outputs 0 on the next edge, and the following en restarts the clear at chan 0.
